// File: rtl/btb_assoc_pkg.sv
// Shared types and constants for the set-associative branch target buffer.
// Statistic ports and counters exist only when BTB_STATS_EN is defined.
package btb_assoc_pkg;

  localparam int unsigned STAT_W = 32;

  typedef enum logic [0:0] {
    BTB_IDLE  = 1'b0,
    BTB_SWEEP = 1'b1
  } btb_state_e;

  // Counter value written on allocation: MSB set, rest clear (weakly taken).
  function automatic int unsigned ctr_weak_taken(input int unsigned ctr_w);
    return 32'(1) << (ctr_w - 1);
  endfunction

endpackage

// File: rtl/btb_lru_select.sv
// True-LRU helper for one set: picks the replacement way and produces the ages after a touch.
module btb_lru_select
  import btb_assoc_pkg::*;
#(
  parameter int unsigned WAYS = 2
) (
  input  logic [WAYS*$clog2(WAYS)-1:0] ages,
  input  logic [WAYS-1:0]              valids,
  input  logic                         hit,
  input  logic [$clog2(WAYS)-1:0]      hit_way,
  output logic [$clog2(WAYS)-1:0]      victim_way,
  output logic                         victim_valid,
  output logic [WAYS*$clog2(WAYS)-1:0] next_ages
);

  localparam int unsigned AGE_W = $clog2(WAYS);

  logic             found_free;
  logic [AGE_W-1:0] touched;
  logic [AGE_W-1:0] touched_age;

  // Lowest-index invalid way wins; otherwise the oldest way (age WAYS-1).
  always_comb begin
    victim_way = '0;
    found_free = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!valids[w] && !found_free) begin
        victim_way = AGE_W'(w);
        found_free = 1'b1;
      end
    end
    if (!found_free) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (ages[w*AGE_W +: AGE_W] == AGE_W'(WAYS - 1)) begin
          victim_way = AGE_W'(w);
        end
      end
    end
    victim_valid = valids[victim_way];
  end

  // Touched way becomes youngest; ways younger than it age by one.
  always_comb begin
    touched     = hit ? hit_way : victim_way;
    touched_age = '0;
    next_ages   = ages;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == touched) begin
        touched_age = ages[w*AGE_W +: AGE_W];
      end
    end
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == touched) begin
        next_ages[w*AGE_W +: AGE_W] = '0;
      end else if (ages[w*AGE_W +: AGE_W] < touched_age) begin
        next_ages[w*AGE_W +: AGE_W] = ages[w*AGE_W +: AGE_W] + AGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// N-way set-associative BTB: combinational lookup, single update port, true-LRU, flush sweep.
// Define BTB_STATS_EN to add saturating hit/allocation/eviction counters and their ports.
module btb_assoc
  import btb_assoc_pkg::*;
#(
  parameter int unsigned SETS   = 8,
  parameter int unsigned WAYS   = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_hit,
  output logic [ADDR_W-1:0] lk_target,
  output logic              lk_taken,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_taken,
  input  logic              flush_req,
  output logic              busy
`ifdef BTB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_allocs,
  output logic [STAT_W-1:0] stat_evicts
`endif
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned AGE_W = $clog2(WAYS);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
  localparam int unsigned ENT   = SETS * WAYS;
  localparam int unsigned ENT_W = IDX_W + AGE_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_weak_taken(CTR_W));

  // Flat storage, entry index = {set, way}.
  logic              valid_q  [ENT];
  logic [TAG_W-1:0]  tag_q    [ENT];
  logic [ADDR_W-1:0] target_q [ENT];
  logic [CTR_W-1:0]  ctr_q    [ENT];
  logic [AGE_W-1:0]  age_q    [ENT];

  btb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  sweep_q, sweep_d;

  logic [IDX_W-1:0]  lk_set, upd_set;
  logic [TAG_W-1:0]  lk_tag, upd_tag;
  logic [1:0]        unused_pc_bits;

  logic                    upd_hit;
  logic [AGE_W-1:0]        upd_way;
  logic [WAYS-1:0]         valid_vec;
  logic [WAYS*AGE_W-1:0]   age_vec;
  logic [WAYS*AGE_W-1:0]   next_ages;
  logic [AGE_W-1:0]        victim_way;
  logic                    victim_valid;
  logic [CTR_W-1:0]        ctr_cur, ctr_nxt;
  logic                    upd_fire, hit_wr, alloc_wr;

  function automatic logic [ENT_W-1:0] ent_idx(input logic [IDX_W-1:0] s,
                                               input logic [AGE_W-1:0] w);
    return {s, w};
  endfunction

  assign lk_set         = lk_pc[IDX_W+1:2];
  assign lk_tag         = lk_pc[ADDR_W-1:IDX_W+2];
  assign upd_set        = upd_pc[IDX_W+1:2];
  assign upd_tag        = upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_pc_bits = lk_pc[1:0] ^ upd_pc[1:0];

  assign busy = (state_q == BTB_SWEEP);

  // Lookup sees pre-edge contents; forced to miss while sweeping.
  always_comb begin
    lk_hit    = 1'b0;
    lk_target = '0;
    lk_taken  = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (state_q == BTB_IDLE && valid_q[ent_idx(lk_set, AGE_W'(w))] &&
          tag_q[ent_idx(lk_set, AGE_W'(w))] == lk_tag) begin
        lk_hit    = 1'b1;
        lk_target = target_q[ent_idx(lk_set, AGE_W'(w))];
        lk_taken  = ctr_q[ent_idx(lk_set, AGE_W'(w))][CTR_W-1];
      end
    end
  end

  // Tag match and per-way state of the update set.
  always_comb begin
    upd_hit   = 1'b0;
    upd_way   = '0;
    valid_vec = '0;
    age_vec   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      valid_vec[w]               = valid_q[ent_idx(upd_set, AGE_W'(w))];
      age_vec[w*AGE_W +: AGE_W]  = age_q[ent_idx(upd_set, AGE_W'(w))];
      if (valid_q[ent_idx(upd_set, AGE_W'(w))] &&
          tag_q[ent_idx(upd_set, AGE_W'(w))] == upd_tag) begin
        upd_hit = 1'b1;
        upd_way = AGE_W'(w);
      end
    end
  end

  btb_lru_select #(
    .WAYS (WAYS)
  ) u_lru (
    .ages         (age_vec),
    .valids       (valid_vec),
    .hit          (upd_hit),
    .hit_way      (upd_way),
    .victim_way   (victim_way),
    .victim_valid (victim_valid),
    .next_ages    (next_ages)
  );

  // Saturating direction counter step for the hitting way.
  always_comb begin
    ctr_cur = ctr_q[ent_idx(upd_set, upd_way)];
    ctr_nxt = ctr_cur;
    if (upd_taken) begin
      if (ctr_cur != '1) ctr_nxt = ctr_cur + CTR_W'(1);
    end else begin
      if (ctr_cur != '0) ctr_nxt = ctr_cur - CTR_W'(1);
    end
  end

  assign upd_fire = upd_valid && (state_q == BTB_IDLE);
  assign hit_wr   = upd_fire && upd_hit;
  assign alloc_wr = upd_fire && !upd_hit && upd_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENT; i++) begin
        valid_q[ENT_W'(i)]  <= 1'b0;
        tag_q[ENT_W'(i)]    <= '0;
        target_q[ENT_W'(i)] <= '0;
        ctr_q[ENT_W'(i)]    <= '0;
        age_q[ENT_W'(i)]    <= AGE_W'(i);
      end
    end else if (state_q == BTB_SWEEP) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        valid_q[ent_idx(sweep_q, AGE_W'(w))] <= 1'b0;
        age_q[ent_idx(sweep_q, AGE_W'(w))]   <= AGE_W'(w);
      end
    end else if (hit_wr) begin
      target_q[ent_idx(upd_set, upd_way)] <= upd_target;
      ctr_q[ent_idx(upd_set, upd_way)]    <= ctr_nxt;
      for (int unsigned w = 0; w < WAYS; w++) begin
        age_q[ent_idx(upd_set, AGE_W'(w))] <= next_ages[w*AGE_W +: AGE_W];
      end
    end else if (alloc_wr) begin
      valid_q[ent_idx(upd_set, victim_way)]  <= 1'b1;
      tag_q[ent_idx(upd_set, victim_way)]    <= upd_tag;
      target_q[ent_idx(upd_set, victim_way)] <= upd_target;
      ctr_q[ent_idx(upd_set, victim_way)]    <= CTR_INIT;
      for (int unsigned w = 0; w < WAYS; w++) begin
        age_q[ent_idx(upd_set, AGE_W'(w))] <= next_ages[w*AGE_W +: AGE_W];
      end
    end
  end

  // Flush sweep: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BTB_IDLE;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Flush sweep: one set per cycle, flush_req ignored while sweeping.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      BTB_IDLE: begin
        if (flush_req) begin
          state_d = BTB_SWEEP;
          sweep_d = '0;
        end
      end
      BTB_SWEEP: begin
        sweep_d = sweep_q + IDX_W'(1);
        if (sweep_q == IDX_W'(SETS - 1)) begin
          state_d = BTB_IDLE;
          sweep_d = '0;
        end
      end
      default: begin
        state_d = BTB_IDLE;
        sweep_d = '0;
      end
    endcase
  end

`ifdef BTB_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_allocs <= '0;
      stat_evicts <= '0;
    end else begin
      if (lk_hit && stat_hits != '1) stat_hits <= stat_hits + STAT_W'(1);
      if (alloc_wr && stat_allocs != '1) stat_allocs <= stat_allocs + STAT_W'(1);
      if (alloc_wr && victim_valid && stat_evicts != '1) stat_evicts <= stat_evicts + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// Scoreboard bench for btb_assoc: recency-list reference model, directed then random stimulus.
module tb_btb_assoc;

  localparam int unsigned SETS   = 8;
  localparam int unsigned WAYS   = 2;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CTR_W  = 2;
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int          CTR_MAX = (1 << CTR_W) - 1;
  localparam int          CTR_MID = 1 << (CTR_W - 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] lk_pc;
  logic              lk_hit;
  logic [ADDR_W-1:0] lk_target;
  logic              lk_taken;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_taken;
  logic              flush_req;
  logic              busy;
`ifdef BTB_STATS_EN
  logic [31:0]       stat_hits, stat_allocs, stat_evicts;
`endif

  always #5 clk = ~clk;

  btb_assoc #(
    .SETS   (SETS),
    .WAYS   (WAYS),
    .ADDR_W (ADDR_W),
    .CTR_W  (CTR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lk_pc      (lk_pc),
    .lk_hit     (lk_hit),
    .lk_target  (lk_target),
    .lk_taken   (lk_taken),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken),
    .flush_req  (flush_req),
    .busy       (busy)
`ifdef BTB_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_allocs (stat_allocs),
    .stat_evicts (stat_evicts)
`endif
  );

  typedef struct {
    logic        hit;
    logic [31:0] tgt;
    logic        taken;
    logic        busy;
    logic [31:0] hits;
    logic [31:0] allocs;
    logic [31:0] evicts;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: per set, valid entries ordered most- to least-recently used.
  int          m_n   [SETS];
  logic [31:0] m_tag [SETS][WAYS];
  logic [31:0] m_tgt [SETS][WAYS];
  int          m_ctr [SETS][WAYS];
  int          sweep_left = 0;
  logic [31:0] m_hits = 0, m_allocs = 0, m_evicts = 0;

  function automatic int set_of(input logic [31:0] pc);
    return int'((pc >> 2) % SETS);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++) m_n[s] = 0;
  endfunction

  function automatic int m_find(input logic [31:0] pc);
    int s = set_of(pc);
    for (int k = 0; k < m_n[s]; k++)
      if (m_tag[s][k] == tag_of(pc)) return k;
    return -1;
  endfunction

  function automatic void m_to_front(input int s, input int k);
    logic [31:0] t = m_tag[s][k];
    logic [31:0] g = m_tgt[s][k];
    int          c = m_ctr[s][k];
    for (int j = k; j > 0; j--) begin
      m_tag[s][j] = m_tag[s][j-1];
      m_tgt[s][j] = m_tgt[s][j-1];
      m_ctr[s][j] = m_ctr[s][j-1];
    end
    m_tag[s][0] = t;
    m_tgt[s][0] = g;
    m_ctr[s][0] = c;
  endfunction

  function automatic void m_update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    int s = set_of(pc);
    int k = m_find(pc);
    if (k >= 0) begin
      m_tgt[s][k] = tgt;
      if (tk && m_ctr[s][k] < CTR_MAX) m_ctr[s][k]++;
      if (!tk && m_ctr[s][k] > 0) m_ctr[s][k]--;
      m_to_front(s, k);
    end else if (tk) begin
      m_allocs++;
      if (m_n[s] == WAYS) m_evicts++;
      else m_n[s]++;
      m_tag[s][m_n[s]-1] = tag_of(pc);
      m_tgt[s][m_n[s]-1] = tgt;
      m_ctr[s][m_n[s]-1] = CTR_MID;
      m_to_front(s, m_n[s] - 1);
    end
  endfunction

  // Drive one cycle, push the expected outputs for it, then advance the model past the edge.
  task automatic step(input logic r, input logic [31:0] lpc, input logic uv,
                      input logic [31:0] upc, input logic [31:0] utgt,
                      input logic ut, input logic fr);
    exp_t e;
    int   k;
    rst = r; lk_pc = lpc; upd_valid = uv; upd_pc = upc;
    upd_target = utgt; upd_taken = ut; flush_req = fr;
    e.busy = (sweep_left != 0);
    e.hit = 1'b0; e.tgt = 32'h0; e.taken = 1'b0;
    if (!e.busy) begin
      k = m_find(lpc);
      if (k >= 0) begin
        e.hit   = 1'b1;
        e.tgt   = m_tgt[set_of(lpc)][k];
        e.taken = (m_ctr[set_of(lpc)][k] >= CTR_MID);
      end
    end
    e.hits = m_hits; e.allocs = m_allocs; e.evicts = m_evicts;
    exp_q.push_back(e);
    if (r) begin
      m_clear();
      sweep_left = 0;
      m_hits = 0; m_allocs = 0; m_evicts = 0;
    end else begin
      if (e.hit) m_hits++;
      if (e.busy) sweep_left--;
      else begin
        if (uv) m_update(upc, utgt, ut);
        if (fr) begin
          m_clear();
          sweep_left = SETS;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    step(1'b0, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    step(1'b0, pc, 1'b1, pc, tgt, tk, 1'b0);
  endtask

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor: compares the DUT against the oldest expectation once per cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("lk_hit",    32'(lk_hit),   32'(e.hit));
      chk("lk_target", lk_target,     e.tgt);
      chk("lk_taken",  32'(lk_taken), 32'(e.taken));
      chk("busy",      32'(busy),     32'(e.busy));
`ifdef BTB_STATS_EN
      chk("stat_hits",   stat_hits,   e.hits);
      chk("stat_allocs", stat_allocs, e.allocs);
      chk("stat_evicts", stat_evicts, e.evicts);
`endif
    end
  end

  function automatic logic [31:0] rand_pc();
    logic [31:0] t = 32'($urandom_range(0, 4));
    logic [31:0] s = 32'($urandom_range(0, SETS - 1));
    return (t << (IDX_W + 2)) | (s << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    rst = 1'b1; lk_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_target = '0; upd_taken = 1'b0; flush_req = 1'b0;
    m_clear();
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset state and first allocation with same-cycle lookup.
    step(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    look(32'h100);
    step(1'b0, 32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0);
    look(32'h100);

    // Counter saturation both ways.
    for (int i = 0; i < 4; i++) upd(32'h100, 32'h200, 1'b0);
    look(32'h100);
    for (int i = 0; i < 4; i++) upd(32'h100, 32'h204, 1'b1);
    look(32'h100);

    // LRU eviction within set 0.
    step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    upd(32'h100, 32'h1000, 1'b1);
    upd(32'h120, 32'h2000, 1'b1);
    upd(32'h100, 32'h1004, 1'b1);
    upd(32'h140, 32'h3000, 1'b1);
    look(32'h120);
    look(32'h100);
    look(32'h140);

    // Not-taken miss does not allocate.
    upd(32'h888, 32'h4000, 1'b0);
    look(32'h888);

    // Flush with an update attempted mid-sweep.
    for (int i = 0; i < SETS; i++) upd(32'h1000 + 32'(i * 4), 32'h5000 + 32'(i), 1'b1);
    look(32'h1004);
    step(1'b0, 32'h1004, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h1004, 1'b1, 32'h1008, 32'h6000, 1'b1, 1'b1);
    for (int i = 0; i < SETS; i++) look(32'h1000 + 32'(i * 4));
    look(32'h1008);

    // Reset in the middle of a sweep.
    upd(32'h100, 32'h1000, 1'b1);
    step(1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    look(32'h100);
    look(32'h100);
    step(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    look(32'h100);
    upd(32'h100, 32'h1000, 1'b1);
    look(32'h100);

    // Randomized traffic over a small PC pool to force conflicts.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] upc;
      upc = rand_pc();
      step(($urandom_range(0, 299) == 0), rand_pc(), ($urandom_range(0, 1) == 1),
           upc, 32'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
    end

    @(negedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
